// File: rtl/regfile_shadow_if.sv
// regfile_shadow_if
//   Bundles the write port, both read ports and the save/restore control
//   of regfile_shadow into one interface.
//   master : writeback / decode / control-unit side (drives requests)
//   slave  : register file side (drives read data and status)
//   Signals:
//     wr, wa, wdata         write enable, address, data
//     ra0/rdata0, ra1/rdata1 read address / data, ports 0 and 1
//     save, restore         sequence requests
//     busy, done, wr_reject sequence status and dropped-write pulse
interface regfile_shadow_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              wr;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] ra0;
  logic [DATA_W-1:0] rdata0;
  logic [ADDR_W-1:0] ra1;
  logic [DATA_W-1:0] rdata1;
  logic              save;
  logic              restore;
  logic              busy;
  logic              done;
  logic              wr_reject;

  modport master (
    output wr, wa, wdata, ra0, ra1, save, restore,
    input  rdata0, rdata1, busy, done, wr_reject
  );

  modport slave (
    input  wr, wa, wdata, ra0, ra1, save, restore,
    output rdata0, rdata1, busy, done, wr_reject
  );
endinterface

// File: rtl/regfile_shadow.sv
// regfile_shadow
//   Register file with one write port, two combinational read ports and a
//   shadow bank. A save copies main -> shadow one entry per cycle, a restore
//   copies shadow -> main one entry per cycle; each sequence keeps busy high
//   for NREGS cycles and ends with a one-cycle done pulse.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous, active-high reset (clears both banks and the FSM)
//     bus  regfile_shadow_if.slave (write, read, save/restore, status)
//   NREGS must equal 2**ADDR_W so the index counter wraps by itself.
//
//   state   | meaning
//   IDLE    | normal operation, writes accepted, waiting for save/restore
//   SAVE    | copying main[idx] -> shadow[idx], writes rejected
//   RESTORE | copying shadow[idx] -> main[idx], writes rejected
module regfile_shadow #(
  parameter int DATA_W  = 16,
  parameter int NREGS   = 8,
  parameter int ADDR_W  = 3,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input logic             clk,
  input logic             rst,
  regfile_shadow_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);
  localparam bit BP = (BYPASS != 0);
  localparam bit ZR = (ZERO_R0 != 0);

  state_t            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] idx_d;
  logic              done_q;
  logic              wr_reject_q;
  logic [DATA_W-1:0] main_q [NREGS];
  logic [DATA_W-1:0] shad_q [NREGS];

  logic              busy;
  logic              wr_ok;
  logic [DATA_W-1:0] rd0;
  logic [DATA_W-1:0] rd1;

  assign busy  = (state_q != IDLE);
  assign idx_d = idx_q + 1'b1;
  // Entry 0 is hardwired when ZR, so its writes vanish without a reject.
  assign wr_ok = bus.wr && !(ZR && (bus.wa == '0));

  // Zero-entry forcing is applied last so it overrides the bypass.
  always_comb begin
    rd0 = main_q[bus.ra0];
    if (BP && bus.wr && !busy && (bus.wa == bus.ra0)) rd0 = bus.wdata;
    if (ZR && (bus.ra0 == '0)) rd0 = '0;
  end

  always_comb begin
    rd1 = main_q[bus.ra1];
    if (BP && bus.wr && !busy && (bus.wa == bus.ra1)) rd1 = bus.wdata;
    if (ZR && (bus.ra1 == '0)) rd1 = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      done_q      <= 1'b0;
      wr_reject_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        main_q[i] <= '0;
        shad_q[i] <= '0;
      end
    end else begin
      done_q      <= 1'b0;
      // Any write attempt while a sequence runs is dropped and flagged,
      // regardless of address.
      wr_reject_q <= bus.wr && busy;
      case (state_q)
        IDLE: begin
          // The write lands on the accepting edge too, so a save captures
          // it and a restore later overwrites it.
          if (wr_ok) main_q[bus.wa] <= bus.wdata;
          if (bus.save) begin
            state_q <= SAVE;
            idx_q   <= '0;
          end else if (bus.restore) begin
            state_q <= RESTORE;
            idx_q   <= '0;
          end
        end
        SAVE: begin
          shad_q[idx_q] <= main_q[idx_q];
          idx_q         <= idx_d;
          if (idx_q == LAST_IDX) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        RESTORE: begin
          if (!(ZR && (idx_q == '0))) main_q[idx_q] <= shad_q[idx_q];
          idx_q <= idx_d;
          if (idx_q == LAST_IDX) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign bus.rdata0    = rd0;
  assign bus.rdata1    = rd1;
  assign bus.busy      = busy;
  assign bus.done      = done_q;
  assign bus.wr_reject = wr_reject_q;

endmodule

// File: tb/tb_regfile_shadow.sv
module tb_regfile_shadow;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int N  = 8;
  localparam int ND = 3;

  // dut 0: BYPASS=1 ZERO_R0=0, dut 1: BYPASS=0 ZERO_R0=0, dut 2: BYPASS=1 ZERO_R0=1
  bit cfg_byp [ND] = '{1'b1, 1'b0, 1'b1};
  bit cfg_zr  [ND] = '{1'b0, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          wr = 1'b0;
  logic [AW-1:0] wa = '0;
  logic [DW-1:0] wdata = '0;
  logic [AW-1:0] ra0 = '0;
  logic [AW-1:0] ra1 = '0;
  logic          save = 1'b0;
  logic          restore = 1'b0;

  regfile_shadow_if #(.DATA_W(DW), .ADDR_W(AW)) if_a ();
  regfile_shadow_if #(.DATA_W(DW), .ADDR_W(AW)) if_b ();
  regfile_shadow_if #(.DATA_W(DW), .ADDR_W(AW)) if_c ();

  assign if_a.wr = wr;  assign if_a.wa = wa;  assign if_a.wdata = wdata;
  assign if_a.ra0 = ra0; assign if_a.ra1 = ra1;
  assign if_a.save = save; assign if_a.restore = restore;
  assign if_b.wr = wr;  assign if_b.wa = wa;  assign if_b.wdata = wdata;
  assign if_b.ra0 = ra0; assign if_b.ra1 = ra1;
  assign if_b.save = save; assign if_b.restore = restore;
  assign if_c.wr = wr;  assign if_c.wa = wa;  assign if_c.wdata = wdata;
  assign if_c.ra0 = ra0; assign if_c.ra1 = ra1;
  assign if_c.save = save; assign if_c.restore = restore;

  regfile_shadow #(.DATA_W(DW), .NREGS(N), .ADDR_W(AW), .BYPASS(1), .ZERO_R0(0))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  regfile_shadow #(.DATA_W(DW), .NREGS(N), .ADDR_W(AW), .BYPASS(0), .ZERO_R0(0))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));
  regfile_shadow #(.DATA_W(DW), .NREGS(N), .ADDR_W(AW), .BYPASS(1), .ZERO_R0(1))
    dut_c (.clk(clk), .rst(rst), .bus(if_c));

  logic [DW-1:0] rd0 [ND];
  logic [DW-1:0] rd1 [ND];
  logic          bsy [ND];
  logic          dn  [ND];
  logic          rj  [ND];
  assign rd0[0] = if_a.rdata0; assign rd1[0] = if_a.rdata1;
  assign bsy[0] = if_a.busy;   assign dn[0]  = if_a.done; assign rj[0] = if_a.wr_reject;
  assign rd0[1] = if_b.rdata0; assign rd1[1] = if_b.rdata1;
  assign bsy[1] = if_b.busy;   assign dn[1]  = if_b.done; assign rj[1] = if_b.wr_reject;
  assign rd0[2] = if_c.rdata0; assign rd1[2] = if_c.rdata1;
  assign bsy[2] = if_c.busy;   assign dn[2]  = if_c.done; assign rj[2] = if_c.wr_reject;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
  endtask

  // Reference model: bank contents plus "cycles of sequence remaining".
  logic [DW-1:0] m_main [ND][N];
  logic [DW-1:0] m_shad [ND][N];
  int            m_left [ND];
  bit            m_rest [ND];
  bit            m_done [ND];
  bit            m_rej  [ND];

  int cnt_busy [ND];
  int cnt_done [ND];
  int cnt_rej  [ND];

  task automatic model_reset();
    for (int k = 0; k < ND; k++) begin
      for (int i = 0; i < N; i++) begin
        m_main[k][i] = '0;
        m_shad[k][i] = '0;
      end
      m_left[k] = 0; m_rest[k] = 1'b0; m_done[k] = 1'b0; m_rej[k] = 1'b0;
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input int k, input logic [AW-1:0] ra);
    if (cfg_zr[k] && ra == '0) return '0;
    if (cfg_byp[k] && wr && m_left[k] == 0 && wa == ra) return wdata;
    return m_main[k][ra];
  endfunction

  // Effect of one rising edge, using the inputs presented before it.
  task automatic model_edge();
    for (int k = 0; k < ND; k++) begin
      bit b;
      b = (m_left[k] > 0);
      m_done[k] = (m_left[k] == 1);
      m_rej[k]  = wr && b;
      if (!b) begin
        if (wr && !(cfg_zr[k] && wa == '0)) m_main[k][wa] = wdata;
        if (save) begin
          // main is frozen during a save, so the copy is just a snapshot
          for (int i = 0; i < N; i++) m_shad[k][i] = m_main[k][i];
          m_left[k] = N; m_rest[k] = 1'b0;
        end else if (restore) begin
          m_left[k] = N; m_rest[k] = 1'b1;
        end
      end else begin
        int p;
        p = N - m_left[k];
        if (m_rest[k] && !(cfg_zr[k] && p == 0)) m_main[k][p] = m_shad[k][p];
        m_left[k]--;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < ND; k++) begin
      chk("rdata0", k, 32'(rd0[k]), 32'(exp_rd(k, ra0)));
      chk("rdata1", k, 32'(rd1[k]), 32'(exp_rd(k, ra1)));
      chk("busy", k, 32'(bsy[k]), 32'(m_left[k] > 0));
      chk("done", k, 32'(dn[k]), 32'(m_done[k]));
      chk("wr_reject", k, 32'(rj[k]), 32'(m_rej[k]));
      if (bsy[k] === 1'b1) cnt_busy[k]++;
      if (dn[k] === 1'b1) cnt_done[k]++;
      if (rj[k] === 1'b1) cnt_rej[k]++;
    end
  endtask

  task automatic clr_counts();
    for (int k = 0; k < ND; k++) begin
      cnt_busy[k] = 0; cnt_done[k] = 0; cnt_rej[k] = 0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_in();
    wr = 1'b0; save = 1'b0; restore = 1'b0;
  endtask

  // Asserts rst between edges, checks the cleared state while it is held,
  // then releases just after a rising edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    model_reset();
    idle_in();
    #1;
    for (int k = 0; k < ND; k++) begin
      chk("rst_busy", k, 32'(bsy[k]), 32'd0);
      chk("rst_done", k, 32'(dn[k]), 32'd0);
      chk("rst_rej", k, 32'(rj[k]), 32'd0);
    end
    for (int i = 0; i < N; i++) begin
      ra0 = AW'(i); ra1 = AW'(N - 1 - i);
      #1;
      for (int k = 0; k < ND; k++) begin
        chk("rst_rd0", k, 32'(rd0[k]), 32'd0);
        chk("rst_rd1", k, 32'(rd1[k]), 32'd0);
      end
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  typedef struct {
    bit            wr;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [DW-1:0] a0, a1;  // expected with bypass
    logic [DW-1:0] b0, b1;  // expected without bypass
  } vec_t;

  vec_t vec [6];

  task automatic write_reg(input int a, input logic [DW-1:0] d);
    wr = 1'b1; wa = AW'(a); wdata = d;
    cycle();
    wr = 1'b0;
  endtask

  task automatic run_idle(input int n);
    idle_in();
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    vec[0] = '{1'b1, 3'd3, 16'h1234, 3'd3, 3'd5, 16'h1234, 16'h0000, 16'h0000, 16'h0000};
    vec[1] = '{1'b1, 3'd5, 16'hBEEF, 3'd3, 3'd5, 16'h1234, 16'hBEEF, 16'h1234, 16'h0000};
    vec[2] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd5, 16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF};
    vec[3] = '{1'b1, 3'd2, 16'h0001, 3'd2, 3'd3, 16'h0001, 16'h1234, 16'h0000, 16'h1234};
    vec[4] = '{1'b1, 3'd2, 16'h00AA, 3'd2, 3'd0, 16'h00AA, 16'h0000, 16'h0001, 16'h0000};
    vec[5] = '{1'b0, 3'd0, 16'h0000, 3'd2, 3'd5, 16'h00AA, 16'hBEEF, 16'h00AA, 16'hBEEF};

    model_reset();
    clr_counts();
    #12;
    do_reset();

    // Basic read/write and bypass table
    foreach (vec[v]) begin
      wr = vec[v].wr; wa = vec[v].wa; wdata = vec[v].wd;
      ra0 = vec[v].ra0; ra1 = vec[v].ra1;
      #1;
      chk("tbl_a_rd0", 0, 32'(rd0[0]), 32'(vec[v].a0));
      chk("tbl_a_rd1", 0, 32'(rd1[0]), 32'(vec[v].a1));
      chk("tbl_b_rd0", 1, 32'(rd0[1]), 32'(vec[v].b0));
      chk("tbl_b_rd1", 1, 32'(rd1[1]), 32'(vec[v].b1));
      chk("tbl_c_rd0", 2, 32'(rd0[2]), 32'(vec[v].a0));
      chk("tbl_c_rd1", 2, 32'(rd1[2]), 32'(vec[v].a1));
      cycle();
    end
    idle_in();

    // Save/restore round trip
    for (int i = 0; i < N; i++) write_reg(i, DW'(16'h1000 + i));
    clr_counts();
    save = 1'b1; cycle(); save = 1'b0;
    run_idle(10);
    for (int k = 0; k < ND; k++) begin
      chk("save_busy_len", k, 32'(cnt_busy[k]), 32'(N));
      chk("save_done_cnt", k, 32'(cnt_done[k]), 32'd1);
    end
    for (int i = 0; i < N; i++) write_reg(i, 16'hFFFF);
    clr_counts();
    restore = 1'b1; cycle(); restore = 1'b0;
    run_idle(10);
    for (int k = 0; k < ND; k++) begin
      chk("rest_busy_len", k, 32'(cnt_busy[k]), 32'(N));
      chk("rest_done_cnt", k, 32'(cnt_done[k]), 32'd1);
    end
    for (int i = 0; i < N; i++) begin
      ra0 = AW'(i);
      cycle();
      for (int k = 0; k < ND; k++)
        chk("restored", k, 32'(rd0[k]), (cfg_zr[k] && i == 0) ? 32'd0 : 32'(16'h1000 + i));
    end

    // Busy collisions: write and restore during a save
    clr_counts();
    save = 1'b1; cycle(); save = 1'b0;
    run_idle(2);
    wr = 1'b1; wa = 3'd4; wdata = 16'hDEAD; restore = 1'b1;
    cycle();
    run_idle(12);
    ra0 = 3'd4; #1;
    for (int k = 0; k < ND; k++) begin
      chk("coll_busy_len", k, 32'(cnt_busy[k]), 32'(N));
      chk("coll_done_cnt", k, 32'(cnt_done[k]), 32'd1);
      chk("coll_rej_cnt", k, 32'(cnt_rej[k]), 32'd1);
      chk("coll_r4", k, 32'(rd0[k]), 32'h1004);
    end

    // Save beats restore; zero-entry writes
    write_reg(1, 16'h7777);
    clr_counts();
    save = 1'b1; restore = 1'b1; cycle(); idle_in();
    run_idle(10);
    restore = 1'b1; cycle(); restore = 1'b0;
    run_idle(10);
    ra0 = 3'd1; #1;
    for (int k = 0; k < ND; k++) begin
      chk("prio_r1", k, 32'(rd0[k]), 32'h7777);
      chk("prio_busy_len", k, 32'(cnt_busy[k]), 32'(2 * N));
    end
    clr_counts();
    ra0 = 3'd0; wr = 1'b1; wa = 3'd0; wdata = 16'h5555; #1;
    chk("r0_bypass", 0, 32'(rd0[0]), 32'h5555);
    chk("r0_zero_now", 2, 32'(rd0[2]), 32'd0);
    cycle(); wr = 1'b0;
    run_idle(2);
    chk("r0_after", 0, 32'(rd0[0]), 32'h5555);
    chk("r0_zero_after", 2, 32'(rd0[2]), 32'd0);
    chk("r0_no_rej", 2, 32'(cnt_rej[2]), 32'd0);

    // Reset in the middle of a restore, then a clean save
    restore = 1'b1; cycle(); restore = 1'b0;
    run_idle(3);
    for (int k = 0; k < ND; k++) chk("mid_busy_pre", k, 32'(bsy[k]), 32'd1);
    clr_counts();
    do_reset();
    run_idle(3);
    for (int k = 0; k < ND; k++) chk("mid_no_done", k, 32'(cnt_done[k]), 32'd0);
    write_reg(6, 16'h0606);
    clr_counts();
    save = 1'b1; cycle(); save = 1'b0;
    run_idle(10);
    for (int k = 0; k < ND; k++) begin
      chk("post_busy_len", k, 32'(cnt_busy[k]), 32'(N));
      chk("post_done_cnt", k, 32'(cnt_done[k]), 32'd1);
    end

    // Randomised traffic against the model
    for (int c = 0; c < 1500; c++) begin
      wr      = ($urandom_range(0, 2) != 0);
      wa      = AW'($urandom_range(0, N - 1));
      wdata   = DW'($urandom);
      ra0     = AW'($urandom_range(0, N - 1));
      ra1     = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, N - 1));
      save    = ($urandom_range(0, 19) == 0);
      restore = ($urandom_range(0, 19) == 0);
      if (m_left[0] > 0 && wa == '0) wr = 1'b0;
      cycle();
    end
    idle_in();
    run_idle(N + 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/regfile_shadow.md
Name: regfile_shadow

Overview:
- Parametrised multi-entry register file: one write port, two combinational read ports, optional write-through bypass, optional hardwired-zero entry 0.
- Adds a shadow bank with multi-cycle save and restore sequencing, used for context switch and interrupt entry/exit.
- Sits between the decode/execute stage (read ports) and writeback (write port).
- The control unit drives save/restore and holds writeback while busy is high.

Parameters:
DATA_W, 16, width of each register in bits
NREGS, 8, number of registers; must be a power of two, at least 2
ADDR_W, 3, address width; must equal log2(NREGS)
BYPASS, 1, 1 = a same-cycle write to the read address is forwarded to the read data
ZERO_R0, 0, 1 = entry 0 always reads 0 and ignores writes and restores

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
wr  input  1  write enable
wa  input  ADDR_W  write address
wdata  input  DATA_W  write data
ra0  input  ADDR_W  read address, port 0
rdata0  output  DATA_W  read data, port 0
ra1  input  ADDR_W  read address, port 1
rdata1  output  DATA_W  read data, port 1
save  input  1  request copy of main bank to shadow bank
restore  input  1  request copy of shadow bank to main bank
busy  output  1  save or restore sequence in progress
done  output  1  one-cycle pulse when a sequence completes
wr_reject  output  1  one-cycle pulse when a write is dropped because busy is high

Behaviour:
- Reset: rst is asynchronous and active-high.
  - While rst=1, all main and shadow entries are 0, the FSM is in IDLE, the index counter is 0, and busy, done and wr_reject are 0.
  - Reset mid-sequence aborts the sequence; no done pulse is issued.
- Read path (combinational, zero latency): rdataN = main[raN].
  - If BYPASS=1 and wr=1, busy=0 and wa==raN, then rdataN = wdata.
  - If ZERO_R0=1 and raN==0, rdataN = 0; this takes priority over bypass.
- Write: at a rising edge with wr=1 and busy=0, main[wa] <= wdata.
  - With ZERO_R0=1, a write to wa=0 is silently dropped and does not raise wr_reject.
  - If wr=1 while busy=1, the write is dropped and wr_reject=1 in the next cycle, for one cycle.
- FSM states: IDLE, SAVE, RESTORE.
  - IDLE: at an edge with save=1, go to SAVE with idx=0. Otherwise, at an edge with restore=1, go to RESTORE with idx=0. If both are 1, save wins.
  - A write presented at the same edge a sequence is accepted (busy still 0) is performed first. It is therefore included in a save and overwritten by a restore if the restore reaches that index.
  - SAVE: each edge, shadow[idx] <= main[idx] and idx increments. At the edge where idx==NREGS-1, go to IDLE, set idx=0 and register done=1.
  - RESTORE: same structure, main[idx] <= shadow[idx]. With ZERO_R0=1, main[0] stays 0.
  - save and restore are ignored while busy=1; no queuing.
- Timing: busy = (state != IDLE).
  - busy is high for exactly NREGS cycles after the accepting edge.
  - done is high for the one cycle immediately after busy falls.
  - A new request may be accepted on the edge ending the done cycle.
- During RESTORE, reads return the current main contents, so entries may be partially restored; consumers must wait for done.
- idx counter is ADDR_W bits and wraps naturally at NREGS-1; no extra terminal logic is needed.
- All state updates are non-blocking at the rising clock edge. No combinational path from save/restore to any output.

Test Plan:
- Reset/basic R/W: assert rst mid-run -> all rdata=0, busy=0. Write 0x1234 to r3 and 0xBEEF to r5; read ra0=3, ra1=5 -> 0x1234, 0xBEEF.
- Bypass: hold r2=0x0001, present wr=1, wa=2, wdata=0x00AA with ra0=2 -> rdata0=0x00AA in the same cycle. With BYPASS=0 -> 0x0001 until after the edge.
- Save/restore round trip: fill r0..r7 with 0x1000+i; pulse save.
  - busy is high 8 cycles, done pulses once after.
  - Overwrite all registers with 0xFFFF; pulse restore -> after done, ri reads 0x1000+i.
- Busy collisions: during SAVE, drive wr=1 to r4 and pulse restore.
  - Write is dropped: r4 unchanged, wr_reject pulses once.
  - Restore is ignored: no second busy window.
- Priority and ZERO_R0: with ZERO_R0=1, pulse save and restore together -> SAVE runs. Write 0x5555 to r0 -> reads 0, no wr_reject.
- Reset mid-sequence: assert rst at idx=3 of RESTORE -> busy=0 immediately, no done, all entries 0. A following save completes normally in 8 cycles.
